// File: rtl/bp_update_ctrl.sv
// Branch-predictor update scheduler: queues branch resolutions and applies each
// one as a read-modify-write of a 2-bit saturating counter in bp_cache.
module bp_update_ctrl #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     upd_valid,
    input  logic [AWIDTH-1:0]        upd_pc,
    input  logic                     upd_taken,
    input  logic                     flush,
    output logic [AWIDTH-1:0]        rd_addr,
    input  logic [DWIDTH-1:0]        rd_data,
    input  logic                     rd_hit,
    output logic                     wr_en,
    output logic [AWIDTH-1:0]        wr_addr,
    output logic [DWIDTH-1:0]        wr_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e              state_q;
    logic [AWIDTH:0]     fifo_mem [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [7:0]          drop_cnt_q;
    logic [AWIDTH-1:0]   work_pc_q;
    logic                work_taken_q;
    logic                wr_en_q;
    logic [AWIDTH-1:0]   wr_addr_q;
    logic [DWIDTH-1:0]   wr_data_q;

    logic                full, empty, push, drop, pop;
    logic [AWIDTH:0]     head;
    logic [1:0]          next_ctr;
    logic                rd_data_unused;

    // Fullness is judged on the pre-edge occupancy, so a same-cycle pop never makes room.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = upd_valid && !flush && !full;
    assign drop  = upd_valid && !flush && full;
    assign pop   = !flush && !empty && (state_q != READ);
    assign head  = fifo_mem[rd_ptr_q];

    assign rd_data_unused = ^rd_data[DWIDTH-1:2];

    function automatic logic [1:0] counter_update(input logic hit, input logic [1:0] c,
                                                  input logic taken);
        if (!hit)
            return taken ? 2'b10 : 2'b01;
        else if (taken)
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else
            return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign next_ctr = counter_update(rd_hit, rd_data[1:0], work_taken_q);

    // NOTE: queue storage carries no reset; occupancy and pointers alone say what is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {upd_pc, upd_taken};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (drop && drop_cnt_q != 8'hFF)
                drop_cnt_q <= drop_cnt_q + 8'd1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // The write of a WRITE cycle is already on the port, so flush only stops what follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            work_pc_q    <= '0;
            work_taken_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q                   <= READ;
                        {work_pc_q, work_taken_q} <= head;
                    end
                end
                READ: begin
                    state_q   <= WRITE;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= work_pc_q;
                    wr_data_q <= {{(DWIDTH-2){1'b0}}, next_ctr};
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    if (!empty) begin
                        state_q                   <= READ;
                        {work_pc_q, work_taken_q} <= head;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_addr  = work_pc_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: table of single-update vectors plus
// hand-written overflow, flush, drop-saturation and async-reset sequences.
module tb_bp_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    bp_update_ctrl #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken),
        .flush     (flush),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        taken;
        logic        hit;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          peak;
    int          nwr;
    int          widx;
    logic [31:0] exp_pc [$];
    logic [31:0] exp_wd [$];

    initial begin
        vecs[0] = '{"miss_taken",    32'h11, 1'b1, 1'b0, 32'h0000_0000, 32'h2};
        vecs[1] = '{"miss_nottaken", 32'h11, 1'b0, 1'b0, 32'h0000_0000, 32'h1};
        vecs[2] = '{"hit3_taken",    32'h20, 1'b1, 1'b1, 32'h0000_0003, 32'h3};
        vecs[3] = '{"hit0_nottaken", 32'h24, 1'b0, 1'b1, 32'h0000_0000, 32'h0};
        vecs[4] = '{"hit1_taken",    32'h28, 1'b1, 1'b1, 32'h0000_0001, 32'h2};
        vecs[5] = '{"hit2_nottaken", 32'h2C, 1'b0, 1'b1, 32'hFFFF_FFF2, 32'h1};
        vecs[6] = '{"hit2_taken",    32'h30, 1'b1, 1'b1, 32'hABCD_0002, 32'h3};
        vecs[7] = '{"miss_ignores",  32'h34, 1'b0, 1'b0, 32'h0000_0003, 32'h1};

        reset = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        flush = 1'b0; rd_data = '0; rd_hit = 1'b0;

        // Reset held for 10 cycles: every output at zero.
        repeat (10) tick();
        check("rst_wr_en",    wr_en,    0);
        check("rst_wr_addr",  wr_addr,  0);
        check("rst_wr_data",  wr_data,  0);
        check("rst_rd_addr",  rd_addr,  0);
        check("rst_busy",     busy,     0);
        check("rst_count",    count,    0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b1;
        nwr = 0;
        repeat (4) begin
            tick();
            if (wr_en) nwr++;
        end
        check("idle_no_write", nwr, 0);
        check("idle_busy", busy, 0);

        // Single updates: push at E0, READ after E1, write cycle after E2, idle after E3.
        for (int i = 0; i < 8; i++) begin
            upd_valid = 1'b1; upd_pc = vecs[i].pc; upd_taken = vecs[i].taken;
            rd_hit = vecs[i].hit; rd_data = vecs[i].rdata;
            tick();
            upd_valid = 1'b0;
            check({vecs[i].name, "_e0_wr_en"}, wr_en, 0);
            check({vecs[i].name, "_e0_count"}, count, 1);
            tick();
            check({vecs[i].name, "_e1_wr_en"}, wr_en, 0);
            check({vecs[i].name, "_e1_rd_addr"}, rd_addr, vecs[i].pc);
            tick();
            check({vecs[i].name, "_e2_wr_en"}, wr_en, 1);
            check({vecs[i].name, "_wr_addr"}, wr_addr, vecs[i].pc);
            check({vecs[i].name, "_wr_data"}, wr_data, vecs[i].exp_data);
            tick();
            check({vecs[i].name, "_e3_wr_en"}, wr_en, 0);
            check({vecs[i].name, "_e3_busy"}, busy, 0);
            check({vecs[i].name, "_hold_addr"}, wr_addr, vecs[i].pc);
        end

        // Overflow: 16 consecutive pushes into a 4-deep queue, all misses.
        rd_hit = 1'b0; rd_data = '0;
        for (int e = 1; e <= 16; e++) begin
            if (!(e >= 8 && (e % 2) == 0)) begin
                exp_pc.push_back(32'h100 + 32'(e));
                exp_wd.push_back((e % 2) == 1 ? 32'h2 : 32'h1);
            end
        end
        peak = 0; nwr = 0; widx = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            upd_valid = (cyc <= 16);
            upd_pc    = 32'h100 + 32'(cyc);
            upd_taken = (cyc % 2) == 1;
            tick();
            if (int'(count) > peak) peak = int'(count);
            if (wr_en) begin
                nwr++;
                if (widx < exp_pc.size()) begin
                    check("ovf_wr_addr", wr_addr, exp_pc[widx]);
                    check("ovf_wr_data", wr_data, exp_wd[widx]);
                end
                widx++;
            end
        end
        upd_valid = 1'b0;
        check("ovf_drop_cnt", drop_cnt, 5);
        check("ovf_peak", peak, 4);
        check("ovf_writes", nwr, 11);
        check("ovf_busy_end", busy, 0);

        // Flush during the first READ, with a concurrent push that must be discarded.
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
        tick();
        upd_pc = 32'h204;
        tick();
        check("fl_read_addr", rd_addr, 32'h200);
        upd_pc = 32'h208; flush = 1'b1;
        tick();
        flush = 1'b0; upd_valid = 1'b0;
        check("fl_count", count, 0);
        check("fl_busy", busy, 0);
        check("fl_wr_en", wr_en, 0);
        check("fl_drop_cnt", drop_cnt, 5);
        nwr = 0;
        repeat (6) begin
            tick();
            if (wr_en) nwr++;
        end
        check("fl_no_write", nwr, 0);
        check("fl_busy_after", busy, 0);

        // Drop counter saturates at 255 rather than wrapping.
        upd_valid = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            upd_pc = 32'h300 + 32'(cyc);
            tick();
        end
        upd_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_drop_cnt", drop_cnt, 255);
        tick();
        check("sat_busy", busy, 0);

        // Async reset during WRITE with a second update still queued.
        upd_valid = 1'b1; upd_pc = 32'h400; upd_taken = 1'b1;
        tick();
        upd_pc = 32'h404;
        tick();
        upd_valid = 1'b0;
        tick();
        check("ar_in_write", wr_en, 1);
        check("ar_queued", count, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_wr_en_now", wr_en, 0);
        check("ar_count", count, 0);
        check("ar_busy", busy, 0);
        check("ar_drop_cnt", drop_cnt, 0);
        check("ar_wr_addr", wr_addr, 0);
        check("ar_rd_addr", rd_addr, 0);
        #20 reset = 1'b1;
        nwr = 0;
        repeat (6) begin
            tick();
            if (wr_en) nwr++;
        end
        check("ar_no_resume", nwr, 0);
        check("ar_clean_count", count, 0);
        check("ar_clean_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
